// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction fetch sequencer: one request to
// instruction memory, then one hand-off to decode, with redirect and halt.
module pc_fetch_sequencer #(
   parameter int              AW       = 32,
   parameter int              DW       = 32,
   parameter logic [AW-1:0]   RESET_PC = {{(AW-2){1'b1}}, 2'b00}
) (
   input  logic          clka,
   input  logic          rsta_n,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [DW-1:0] imem_rdata,
   output logic          instr_valid,
   output logic [DW-1:0] instr,
   output logic [AW-1:0] instr_pc,
   input  logic          dec_ready,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_pc,
   input  logic          halt,
   output logic [AW-1:0] pc,
   output logic          halted
);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      REQ    = 2'd1,
      ISSUE  = 2'd2,
      HALTED = 2'd3
   } state_t;

   localparam logic [AW-1:0] PC_STEP   = {{(AW-3){1'b0}}, 3'b100};
   localparam logic [AW-1:0] ALIGN_MSK = ~{{(AW-2){1'b0}}, 2'b11};

   state_t        state_r;
   logic          redir_pend_r;
   logic [AW-1:0] redir_pc_r;
   logic [AW-1:0] redir_tgt_s;
   logic [AW-1:0] pc_inc_s;

   // Word-aligned redirect target and sequential successor address.
   always_comb begin
      redir_tgt_s = redirect_pc & ALIGN_MSK;
      pc_inc_s    = pc + PC_STEP;
   end

   assign imem_addr = pc;

   // Fetch FSM with registered handshake outputs.
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         state_r      <= BOOT;
         pc           <= RESET_PC;
         imem_req     <= 1'b0;
         instr_valid  <= 1'b0;
         instr        <= {DW{1'b0}};
         instr_pc     <= {AW{1'b0}};
         halted       <= 1'b0;
         redir_pend_r <= 1'b0;
         redir_pc_r   <= {AW{1'b0}};
      end else begin
         case (state_r)
            BOOT: begin
               pc       <= pc_inc_s;
               imem_req <= 1'b1;
               state_r  <= REQ;
            end
            REQ: begin
               if (imem_ack) begin
                  if (redirect || redir_pend_r) begin
                     // In-flight word belongs to the old stream: drop it and
                     // restart at the newest target.
                     pc           <= redirect ? redir_tgt_s : redir_pc_r;
                     redir_pend_r <= 1'b0;
                  end else begin
                     instr       <= imem_rdata;
                     instr_pc    <= pc;
                     imem_req    <= 1'b0;
                     instr_valid <= 1'b1;
                     state_r     <= ISSUE;
                  end
               end else if (redirect) begin
                  redir_pc_r   <= redir_tgt_s;
                  redir_pend_r <= 1'b1;
               end else begin
                  redir_pend_r <= redir_pend_r;
               end
            end
            ISSUE: begin
               if (redirect) begin
                  pc          <= redir_tgt_s;
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
                  state_r     <= REQ;
               end else if (dec_ready) begin
                  instr_valid <= 1'b0;
                  if (halt) begin
                     halted  <= 1'b1;
                     state_r <= HALTED;
                  end else begin
                     pc       <= pc_inc_s;
                     imem_req <= 1'b1;
                     state_r  <= REQ;
                  end
               end else begin
                  instr_valid <= 1'b1;
               end
            end
            HALTED: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
               halted      <= 1'b1;
            end
            default: begin
               state_r      <= BOOT;
               imem_req     <= 1'b0;
               instr_valid  <= 1'b0;
               halted       <= 1'b0;
               redir_pend_r <= 1'b0;
            end
         endcase
      end
   end

endmodule
